// File: rtl/bitrev_pkg.sv
// bitrev_pkg: width-generic bit-reverse helper and per-bank debug state
package bitrev_pkg;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = idx[i];
    return r;
  endfunction
endpackage

// File: rtl/bitrev_bank.sv
// bitrev_bank: one frame of sample storage, sync write, combinational read, async clear
module bitrev_bank #(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ENTRY_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ENTRY_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [ENTRY_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);
  logic [DATA_WIDTH-1:0] mem [NUM_ENTRIES];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/bit_reverse_stream_buffer.sv
// bit_reverse_stream_buffer: ping-pong reorder of bit-reversed frames into natural order.
// Define BITREV_OUT_INDEX_EN to expose the natural-order index as out_index.
module bit_reverse_stream_buffer
  import bitrev_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ENTRY_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
`ifdef BITREV_OUT_INDEX_EN
  ,
  output logic [ENTRY_WIDTH-1:0] out_index
`endif
);
  localparam logic [ENTRY_WIDTH-1:0] LAST = ENTRY_WIDTH'(NUM_ENTRIES - 1);
  logic [1:0] full;
  logic wr_bank, rd_bank, wr_en, rd_en, wr_last, rd_last;
  logic [ENTRY_WIDTH-1:0] wr_cnt, rd_cnt, wr_addr;
  logic [DATA_WIDTH-1:0] rdata [2];
  bank_state_e st [2];
  assign in_ready = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last = out_valid && rd_cnt == LAST;
  assign out_data = rdata[rd_bank];
  assign wr_en = in_valid && in_ready;
  assign rd_en = out_valid && out_ready;
  assign wr_last = wr_en && wr_cnt == LAST;
  assign rd_last = rd_en && rd_cnt == LAST;
  assign wr_addr = ENTRY_WIDTH'(bitrev(32'(wr_cnt), ENTRY_WIDTH));
`ifdef BITREV_OUT_INDEX_EN
  assign out_index = rd_cnt;
`endif
  genvar b;
  for (b = 0; b < 2; b++) begin : g_bank
    bitrev_bank #(.NUM_ENTRIES(NUM_ENTRIES), .DATA_WIDTH(DATA_WIDTH), .ENTRY_WIDTH(ENTRY_WIDTH)) u_bank (
      .clk(clk), .reset(reset), .we(wr_en && wr_bank == 1'(b)), .waddr(wr_addr),
      .wdata(in_data), .raddr(rd_cnt), .rdata(rdata[b])
    );
  end
  // a simultaneous last write and last read touch different banks, so set and clear compose
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + ENTRY_WIDTH'(1);
      if (rd_en) rd_cnt <= rd_cnt + ENTRY_WIDTH'(1);
      wr_bank <= wr_bank ^ wr_last;
      rd_bank <= rd_bank ^ rd_last;
      full <= (full | ({1'b0, wr_last} << wr_bank)) & ~({1'b0, rd_last} << rd_bank);
    end
  always_comb
    for (int i = 0; i < 2; i++)
      st[i] = full[i] ? FULL : (wr_bank == 1'(i) && wr_cnt != '0) ? FILLING : EMPTY;
  always @(posedge clk)
    if (reset) assert ((st[rd_bank] == FULL || rd_cnt == '0) && (st[wr_bank] != FULL || wr_cnt == '0));
endmodule

// File: tb/tb_bit_reverse_stream_buffer.sv
// tb_bit_reverse_stream_buffer: randomized scoreboard bench against a frame-level reorder model
module tb_bit_reverse_stream_buffer;
  localparam int N = 8, DW = 16, EW = 3;
  typedef struct {logic [DW-1:0] d; logic last; int idx;} exp_t;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0, out_data;
  logic in_ready, out_valid, out_last;
`ifdef BITREV_OUT_INDEX_EN
  logic [EW-1:0] out_index;
`endif
  int total = 0, bad = 0, held = 0;
  logic [DW-1:0] frame_q [$];
  exp_t exp_q [$];
  exp_t e;
  logic stall_prev = 0, last_prev = 0, done = 0;
  logic [DW-1:0] data_prev = '0;
  bit_reverse_stream_buffer #(.NUM_ENTRIES(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef BITREV_OUT_INDEX_EN
    , .out_index(out_index)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask
  function automatic int rev(input int k);
    int r = 0;
    for (int m = N; m > 1; m /= 2) begin
      r = r * 2 + k % 2;
      k /= 2;
    end
    return r;
  endfunction
  // monitor: model holds whole frames; a bank is free while fewer than two frames are unread
  always @(negedge clk) begin
    if (!reset) begin
      frame_q.delete();
      exp_q.delete();
      held = 0;
      stall_prev = 0;
    end else begin
      check("in_ready", in_ready, held < 2);
      check("out_valid", out_valid, held > 0);
      if (!out_valid) check("last_idle", out_last, 0);
      if (stall_prev) begin
        check("hold_data", out_data, data_prev);
        check("hold_last", out_last, last_prev);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.last);
`ifdef BITREV_OUT_INDEX_EN
          check("out_index", out_index, e.idx);
`endif
          if (e.last) held--;
        end
      end
      stall_prev = out_valid && !out_ready;
      data_prev = out_data;
      last_prev = out_last;
      if (in_valid && in_ready) begin
        frame_q.push_back(in_data);
        if (frame_q.size() == N) begin
          for (int n = 0; n < N; n++) begin
            e.d = frame_q[rev(n)];
            e.last = (n == N - 1);
            e.idx = n;
            exp_q.push_back(e);
          end
          frame_q.delete();
          held++;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    logic took;
    in_valid = 1;
    in_data = d;
    do begin
      @(negedge clk);
      took = in_ready;
      tick();
      n++;
    end while (!took && n < 300);
    if (!took) check("send_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    tick();
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
`ifdef BITREV_OUT_INDEX_EN
    check({tag, "_out_index"}, out_index, 0);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int v [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1;
    tick();
    out_ready = 1;
    foreach (v[i]) send(DW'(v[i]));
    drain();
    for (int i = 0; i < 3 * N; i++) send(DW'($urandom));
    drain();
    out_ready = 0;
    for (int i = 0; i < 2 * N; i++) send(DW'($urandom));
    check("full_in_ready", in_ready, 0);
    in_valid = 1;
    in_data = 16'hdead;
    repeat (3) tick();
    check("stalled_in_ready", in_ready, 0);
    out_ready = 1;
    send(16'hbeef);
    for (int i = 1; i < N; i++) send(DW'($urandom));
    drain();
    done = 0;
    fork
      begin
        for (int i = 0; i < 10 * N; i++) begin
          repeat ($urandom_range(0, 1)) tick();
          send(DW'($urandom));
        end
        done = 1;
      end
      while (!done) begin
        out_ready = $urandom_range(0, 1) == 1;
        tick();
      end
    join
    drain();
    for (int i = 0; i < 3; i++) send(DW'($urandom));
    reset = 0;
    #1;
    check_reset_outputs("midreset");
    tick();
    reset = 1;
    tick();
    for (int i = 0; i < N; i++) send(DW'($urandom));
    drain();
    check("leftover", exp_q.size() + frame_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bit_reverse_stream_buffer.md
# bit_reverse_stream_buffer

Streaming reorder buffer that converts a serial sample stream arriving in bit-reversed index order, as produced by the radix-2 FFT/IFFT core, into natural index order. It sits between the FFT output and the subcarrier demapper. It is the streaming, handshaked read-side counterpart of the parallel `bit_reverser` permutation. Ping-pong storage sustains one sample per clock while one frame is written and the previous one is read.

## Interface
- `NUM_ENTRIES`, 8, frame length in samples; a power of two, ≥ 2.
- `DATA_WIDTH`, 16, sample width in bits.
- `ENTRY_WIDTH`, `$clog2(NUM_ENTRIES)`, index width; derived, do not override.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in_data`  input  DATA_WIDTH  sample, arriving in bit-reversed order within the frame.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  buffer can accept a sample this cycle.
- `out_data`  output  DATA_WIDTH  sample, in natural order.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  downstream accepts `out_data`.
- `out_last`  output  1  marks natural index NUM_ENTRIES-1 of the frame.

## Operation
- Storage: two banks, each holding NUM_ENTRIES × DATA_WIDTH, plus one `full` flag per bank. Indices used:
  - `wr_bank`, `wr_cnt` on the write side.
  - `rd_bank`, `rd_cnt` on the read side.
- Write accept: a write occurs when `in_valid && in_ready`.
  - `in_ready = !full[wr_bank]`.
  - The sample is stored at `bank[wr_bank][bitrev(wr_cnt)]`, then `wr_cnt` increments.
- Write frame end: when `wr_cnt == NUM_ENTRIES-1` and a write is accepted, set `full[wr_bank]`, toggle `wr_bank`, and wrap `wr_cnt` to 0.
- Read accept: a read occurs when `out_valid && out_ready`.
  - `out_valid = full[rd_bank]`.
  - `out_data = bank[rd_bank][rd_cnt]`, a combinational read of registered storage.
  - `out_last = out_valid && rd_cnt == NUM_ENTRIES-1`.
  - `rd_cnt` increments on each accepted read.
- Read frame end: the read accepted at `rd_cnt == NUM_ENTRIES-1` clears `full[rd_bank]`, toggles `rd_bank`, and wraps `rd_cnt` to 0.
- Per-bank state: EMPTY → FILLING on the first write → FULL on the last write → EMPTY on the last read. The per-bank state is encoded by `full` together with the counters.
- Ordering: banks are always consumed in the order they were filled; `wr_bank` and `rd_bank` both start at 0.
- Arithmetic:
  - Counters are ENTRY_WIDTH bits and wrap naturally.
  - `bitrev` mirrors the ENTRY_WIDTH bits.
  - No arithmetic is applied to the data path.
- Simultaneous last write and last read: these always target different banks. Both flag updates take effect in the same cycle.
- Full buffer: when both banks are FULL, `in_ready` is 0. The writer stalls until the read side releases `wr_bank`.
- Backpressure: `out_ready` low holds `out_data`, `out_valid` and `out_last` stable.
- `in_valid` is ignored while `in_ready` is 0; that sample is not stored.
- Reset mid-frame:
  - All counters, bank pointers and `full` flags clear.
  - Storage clears to 0.
  - Partial frames are discarded.

## Timing
- Reset values:
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_last` = 0
  - `out_data` = 0
- Latency: `out_valid` rises on the clock edge that accepts the NUM_ENTRIES-th input. The first output is visible in the cycle after that acceptance.
- Throughput: one sample per cycle in steady state with `out_ready` held at 1. There are no bubbles between frames.
- Release to `in_ready`: when the last read of a frame frees a bank while the writer is stalled on it, `in_ready` returns to 1 in the following cycle (registered `full`).
- Pass-through: `in_ready` and `out_valid` are registered-flag decodes, with no combinational path from `in_valid`. `out_ready` does not affect `in_ready` within the same cycle.

## Configuration
- `BITREV_OUT_INDEX_EN` defined: adds output port `out_index` [ENTRY_WIDTH-1:0] = `rd_cnt`, the natural-order index of `out_data`. Its reset value is 0 and it is valid whenever `out_valid` is high.
- Macro undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `bitrev_pkg`:
  - `function automatic bitrev(input logic [ENTRY_WIDTH-1:0] idx)`, parameterised via a localparam or a width-generic loop.
  - A `bank_state_e` enum (EMPTY/FILLING/FULL) for debug and assertions.
- Sub-module `bitrev_bank`: one storage bank (write port, combinational read port, async clear), instantiated twice. Pointer, counter and flag control stays in the top module.

## Test plan
- Single frame with N=8, `out_ready`=1: `in_data` = 0,4,2,6,1,5,3,7 → `out_data` = 0..7 on consecutive cycles, `out_last` only on 7, `out_valid` first high in the cycle after the 8th input.
- Three back-to-back frames with `in_valid` held at 1 and `out_ready`=1: `in_ready` stays 1 throughout and outputs are contiguous (24 beats, no gaps after the first frame).
- `out_ready`=0: after 16 accepted inputs `in_ready`=0 and the 17th input is not stored. Raising `out_ready` drains 8 samples, then `in_ready`=1 in the next cycle and frame 3 completes correctly.
- Random `out_ready` (50%) over 10 frames: output order and data match the scoreboard bitrev model, and `out_data` is stable while stalled.
- Assert `reset` low after 3 inputs of a frame, then release: `out_valid`=0, `in_ready`=1, `out_data`=0. The next full frame outputs correctly with no residue.
- With `BITREV_OUT_INDEX_EN` defined: `out_index` follows 0..7 alongside `out_data` for each frame.
